// File: rtl/requant_maxpool.sv
// Requantize 25-bit conv results to 8 bits and 2x2 max-pool them in raster order.
// One pooled byte leaves per completed window, one cycle after its last sample.
module requant_maxpool #(
    parameter int ROW_LEN = 24,
    parameter int COL_LEN = 24,
    parameter int IN_W    = 25,
    parameter int OUT_W   = 8,
    parameter int SHIFT   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             frame_done
);

    localparam int CW = (ROW_LEN > 2) ? $clog2(ROW_LEN) : 1;
    localparam int RW = (COL_LEN > 2) ? $clog2(COL_LEN) : 1;
    localparam int LD = ROW_LEN / 2;
    localparam int LW = (LD > 1) ? $clog2(LD) : 1;

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [OUT_W-1:0] hold_q, hold_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             frame_done_q, frame_done_d;

    logic [OUT_W-1:0] lb_q [LD];
    logic             lb_we;
    logic [LW-1:0]    lb_idx;
    logic [OUT_W-1:0] lb_rd;

    logic [IN_W-1:0]  shifted;
    logic [OUT_W-1:0] q;
    logic [OUT_W-1:0] hmax;
    logic [OUT_W-1:0] pool;
    logic             last_col;
    logic             last_row;

    // Anything above the output range saturates to all-ones.
    always_comb begin
        shifted = in_data >> SHIFT;
        q       = (|shifted[IN_W-1:OUT_W]) ? '1 : shifted[OUT_W-1:0];
        lb_idx  = LW'(col_q >> 1);
        lb_rd   = lb_q[lb_idx];
        hmax    = (q > hold_q) ? q : hold_q;
        pool    = (lb_rd > hmax) ? lb_rd : hmax;
        last_col = (col_q == CW'(ROW_LEN - 1));
        last_row = (row_q == RW'(COL_LEN - 1));
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;
        if (!start) begin
            col_d      = '0;
            row_d      = '0;
            hold_d     = '0;
            out_data_d = '0;
        end else if (in_valid) begin
            if (!col_q[0]) begin
                hold_d = q;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_data_d   = pool;
                out_valid_d  = 1'b1;
                frame_done_d = last_col && last_row;
            end
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_q[lb_idx] <= hmax;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_requant_maxpool.sv
// Bench for requant_maxpool: a 4x4/SHIFT=0 and a 2x2/SHIFT=8 instance
// checked against a window-level reference model.
module tb_requant_maxpool;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        iv_a, iv_b;
    logic [24:0] d_a, d_b;
    logic        ov_a, ov_b, fd_a, fd_b;
    logic [7:0]  od_a, od_b;

    int tests = 0;
    int fails = 0;

    int dim [2] = '{4, 2};
    int shf [2] = '{0, 8};
    int pr [2];
    int pc [2];
    int pix [2][4][4];
    int npulse [2];
    int nfd [2];

    requant_maxpool #(
        .ROW_LEN(4), .COL_LEN(4), .IN_W(25), .OUT_W(8), .SHIFT(0)
    ) u_a (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(iv_a), .in_data(d_a),
        .out_valid(ov_a), .out_data(od_a), .frame_done(fd_a)
    );

    requant_maxpool #(
        .ROW_LEN(2), .COL_LEN(2), .IN_W(25), .OUT_W(8), .SHIFT(8)
    ) u_b (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(iv_b), .in_data(d_b),
        .out_valid(ov_b), .out_data(od_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int rq(int sel, logic [24:0] d);
        logic [24:0] s;
        s = d >> shf[sel];
        return (s > 25'd255) ? 255 : int'(s);
    endfunction

    task automatic step(int sel, bit v, logic [24:0] d);
        bit ev, ef;
        int ed, r, c, n;
        logic ov, fd;
        logic [7:0] od;
        ev = 0; ef = 0; ed = 0;
        n = dim[sel];
        if (sel == 0) begin iv_a = v; d_a = d; end
        else begin iv_b = v; d_b = d; end
        if (!start) begin
            pr[sel] = 0;
            pc[sel] = 0;
        end else if (v) begin
            r = pr[sel];
            c = pc[sel];
            pix[sel][r][c] = rq(sel, d);
            if (r % 2 == 1 && c % 2 == 1) begin
                ev = 1;
                ed = max2(max2(pix[sel][r-1][c-1], pix[sel][r-1][c]),
                          max2(pix[sel][r][c-1], pix[sel][r][c]));
                ef = (r == n - 1) && (c == n - 1);
            end
            c++;
            if (c == n) begin
                c = 0;
                r = (r == n - 1) ? 0 : r + 1;
            end
            pr[sel] = r;
            pc[sel] = c;
        end
        @(posedge clk);
        #1;
        iv_a = 1'b0;
        iv_b = 1'b0;
        ov = (sel == 0) ? ov_a : ov_b;
        od = (sel == 0) ? od_a : od_b;
        fd = (sel == 0) ? fd_a : fd_b;
        chk("out_valid", 32'(ov), 32'(ev));
        if (ev) chk("out_data", 32'(od), 32'(ed));
        chk("frame_done", 32'(fd), 32'(ef));
        if (ov === 1'b1) npulse[sel]++;
        if (fd === 1'b1) nfd[sel]++;
    endtask

    task automatic feed_seq(int sel, int n, int gapmax);
        for (int i = 0; i < n; i++) begin
            step(sel, 1'b1, 25'(i));
            repeat ($urandom_range(0, gapmax)) step(sel, 1'b0, 25'd0);
        end
    endtask

    task automatic feed_rand(int sel, int n, int gapmax, int vmax);
        for (int i = 0; i < n; i++) begin
            step(sel, 1'b1, 25'($urandom_range(0, vmax)));
            repeat ($urandom_range(0, gapmax)) step(sel, 1'b0, 25'd0);
        end
    endtask

    task automatic clear_counts();
        npulse[0] = 0; npulse[1] = 0;
        nfd[0] = 0; nfd[1] = 0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        iv_a = 1'b0; iv_b = 1'b0;
        d_a = '0; d_b = '0;
        pr = '{0, 0}; pc = '{0, 0};
        clear_counts();

        #1;
        chk("rst_valid", 32'(ov_a), 0);
        chk("rst_data", 32'(od_a), 0);
        chk("rst_fdone", 32'(fd_a), 0);
        chk("rst_data_b", 32'(od_b), 0);

        start = 1'b1;
        iv_a = 1'b1; iv_b = 1'b1;
        d_a = 25'd7; d_b = 25'h1FFFFFF;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_hold_valid", 32'({ov_a, ov_b}), 0);
            chk("rst_hold_data", 32'({od_a, od_b}), 0);
        end
        iv_a = 1'b0; iv_b = 1'b0;
        reset = 1'b0;

        clear_counts();
        feed_seq(0, 16, 0);
        chk("basic_pulses", 32'(npulse[0]), 4);
        chk("basic_fdone", 32'(nfd[0]), 1);
        chk("basic_last", 32'(od_a), 15);

        step(1, 1'b1, 25'h1FFFFFF);
        step(1, 1'b1, 25'h3FF);
        step(1, 1'b1, 25'h0);
        step(1, 1'b1, 25'h100);
        chk("sat_out", 32'(od_b), 255);
        step(1, 1'b1, 25'h3FF);
        step(1, 1'b1, 25'h2FF);
        step(1, 1'b1, 25'h0);
        step(1, 1'b1, 25'h100);
        chk("shift_out", 32'(od_b), 3);

        clear_counts();
        feed_seq(0, 16, 5);
        feed_seq(0, 16, 0);
        chk("gap_pulses", 32'(npulse[0]), 8);
        chk("gap_fdone", 32'(nfd[0]), 2);

        clear_counts();
        for (int f = 0; f < 3; f++) begin
            feed_rand(0, 16, 2, 600);
            feed_rand(1, 4, 2, 25'h1FFFFFF);
            feed_rand(1, 4, 1, 25'h1FFFF);
        end
        chk("rand_fdone_a", 32'(nfd[0]), 3);
        chk("rand_fdone_b", 32'(nfd[1]), 6);

        clear_counts();
        feed_seq(0, 6, 1);
        start = 1'b0;
        step(0, 1'b1, 25'd99);
        step(0, 1'b1, 25'd200);
        chk("abort_data", 32'(od_a), 0);
        chk("abort_pulses", 32'(npulse[0]), 1);
        start = 1'b1;
        clear_counts();
        feed_seq(0, 16, 0);
        chk("abort_resume_pulses", 32'(npulse[0]), 4);
        chk("abort_resume_fdone", 32'(nfd[0]), 1);

        clear_counts();
        feed_seq(0, 10, 0);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_data", 32'(od_a), 0);
        chk("midrst_valid", 32'(ov_a), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pr[0] = 0; pc[0] = 0;
        clear_counts();
        feed_seq(0, 16, 0);
        chk("midrst_pulses", 32'(npulse[0]), 4);
        chk("midrst_last", 32'(od_a), 15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
